nrzi_stuff_encoder: RTL and testbench

Serial transmit stage directly upstream of the DP/DM line driver. It accepts raw packet bits (post-CRC, LSB-first) from the packetizer over a valid/ready handshake, inserts a stuffed 0 after every run of six consecutive 1s, and NRZI-encodes the result. Its outputs drive the line driver's `in_bit` / `nrzi_sending` inputs, so the encoded line level must continue seamlessly from the SYNC pattern the driver emits. A further packet is blocked until the driver reports EOP complete.

---
 rtl/nrzi_stuff_encoder_pkg.sv | 18 +
 rtl/nrzi_stuff_encoder_if.sv | 33 +++
 rtl/nrzi_stuff_encoder_ones.sv | 47 ++++
 rtl/nrzi_stuff_encoder.sv | 116 +++++++++++
 tb/tb_nrzi_stuff_encoder.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/nrzi_stuff_encoder_pkg.sv
// Shared transmit-path definitions for the USB serial TX stage.
//   tx_state_e        : encoder FSM states
//   STUFF_RUN_DEFAULT : run of 1s that forces a stuffed 0
//   LVL_J / LVL_K     : line levels carried on the NRZI bit
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        STUFF,
        WAIT_DONE
    } tx_state_e;

    localparam int   STUFF_RUN_DEFAULT = 6;
    localparam logic LVL_J             = 1'b1;
    localparam logic LVL_K             = 1'b0;

endpackage

// File: rtl/nrzi_stuff_encoder_if.sv
// Packetizer/line-driver side bundle of the NRZI bit-stuffing encoder.
//   in_bit, in_valid, in_ready : raw bit handshake from the packetizer
//   tx_done                    : EOP-complete pulse from the line driver
//   out_bit, out_sending       : NRZI line bit and data-valid to the driver
// master = environment (packetizer + driver), slave = encoder.
interface nrzi_stuff_encoder_if;

    logic in_bit;
    logic in_valid;
    logic in_ready;
    logic tx_done;
    logic out_bit;
    logic out_sending;

    modport master (
        output in_bit,
        output in_valid,
        input  in_ready,
        output tx_done,
        input  out_bit,
        input  out_sending
    );

    modport slave (
        input  in_bit,
        input  in_valid,
        output in_ready,
        input  tx_done,
        output out_bit,
        output out_sending
    );

endinterface

// File: rtl/nrzi_stuff_encoder_ones.sv
// Saturating count of consecutive 1s for bit stuffing.
//   clock, reset_n : clock and synchronous active-low reset
//   inc_i          : a 1 is being emitted
//   clr_i          : a 0 (data or stuffed) restarts the run; applied
//                    before inc_i so both together load a count of 1
//   cnt_o          : current run length, never above STUFF_RUN
//   hit_o          : run length equals STUFF_RUN
module ones_run_counter
    import usb_tx_pkg::*;
#(
    parameter  int STUFF_RUN = STUFF_RUN_DEFAULT,
    localparam int CW        = $clog2(STUFF_RUN + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [CW-1:0] cnt_o,
    output logic          hit_o
);

    localparam logic [CW-1:0] RUN = CW'(STUFF_RUN);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] base;

    always_comb begin
        base  = clr_i ? '0 : cnt_q;
        cnt_d = base;
        if (inc_i && (base != RUN)) begin
            cnt_d = base + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign hit_o = (cnt_q == RUN);

endmodule

// File: rtl/nrzi_stuff_encoder.sv
// Bit-stuffing NRZI encoder feeding the DP/DM line driver.
//   clock, reset_n : clock and synchronous active-low reset
//   bus (slave)    : in_bit/in_valid/in_ready from the packetizer,
//                    tx_done from the driver, out_bit/out_sending to it
// A 0 is stuffed after every STUFF_RUN consecutive 1s; the stuffed
// cycle holds in_ready low. The line level starts each packet from K so
// it continues the SYNC pattern already sent by the driver.
module nrzi_stuff_encoder
    import usb_tx_pkg::*;
#(
    parameter int STUFF_RUN = STUFF_RUN_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset_n,
    nrzi_stuff_encoder_if.slave  bus
);

    localparam int            CW     = $clog2(STUFF_RUN + 1);
    localparam logic [CW-1:0] RUN_M1 = CW'(STUFF_RUN - 1);

    tx_state_e     state_q, state_d;
    logic          lvl_q, lvl_d;
    logic          sending_q, sending_d;
    logic          in_ready;
    logic          consume;
    logic          run_done;
    logic [CW-1:0] run_base;
    logic          ones_inc;
    logic          ones_clr;
    logic [CW-1:0] ones_cnt;
    logic          ones_hit;

    assign consume  = bus.in_valid & in_ready;
    // A new packet starts its run from zero regardless of what the last
    // packet left in the counter.
    assign run_base = (state_q == IDLE) ? '0 : ones_cnt;
    assign run_done = bus.in_bit && (run_base == RUN_M1);

    assign ones_inc = consume & bus.in_bit;
    // hit only occurs while in STUFF, so it doubles as the stuffed-0 clear.
    assign ones_clr = (state_q == IDLE) | (consume & ~bus.in_bit) | ones_hit;

    ones_run_counter #(
        .STUFF_RUN (STUFF_RUN)
    ) u_ones (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_i   (ones_inc),
        .clr_i   (ones_clr),
        .cnt_o   (ones_cnt),
        .hit_o   (ones_hit)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            lvl_q     <= LVL_K;
            sending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lvl_q     <= lvl_d;
            sending_q <= sending_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) state_d = run_done ? STUFF : SEND;
            end
            SEND: begin
                if (bus.in_valid) state_d = run_done ? STUFF : SEND;
                else              state_d = WAIT_DONE;
            end
            STUFF: begin
                state_d = SEND;
            end
            WAIT_DONE: begin
                if (bus.tx_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || (state_q == SEND);
        lvl_d     = lvl_q;
        sending_d = sending_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // First bit is encoded against a forced K level.
                    lvl_d     = bus.in_bit ? LVL_K : ~LVL_K;
                    sending_d = 1'b1;
                end
            end
            SEND: begin
                if (bus.in_valid) begin
                    if (!bus.in_bit) lvl_d = ~lvl_q;
                end else begin
                    sending_d = 1'b0;
                end
            end
            STUFF: begin
                lvl_d = ~lvl_q;
            end
            default: ;
        endcase
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_bit     = lvl_q;
    assign bus.out_sending = sending_q;

endmodule

// File: tb/tb_nrzi_stuff_encoder.sv
module tb_nrzi_stuff_encoder;

    logic clock = 1'b0;
    logic reset_n;

    nrzi_stuff_encoder_if bus ();

    nrzi_stuff_encoder #(
        .STUFF_RUN (6)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   send_cycles = 0;
    int   stall_cycles = 0;
    logic exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Monitor: every cycle the DUT presents a line bit, pop and compare.
    always @(negedge clock) begin
        if (bus.out_sending === 1'b1) begin
            send_cycles++;
            if (bus.in_ready === 1'b0) stall_cycles++;
            chk("expected_bit_queued", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) chk("out_bit", {31'd0, bus.out_bit}, {31'd0, exp_q.pop_front()});
        end
    end

    // Vectors are written in time order: leftmost literal bit goes first.
    task automatic push_exp(input logic [15:0] e, input int m);
        for (int j = 0; j < m; j++) exp_q.push_back(e[m-1-j]);
    endtask

    task automatic drive_bits(input logic [15:0] v, input int n);
        int g;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus.in_valid = 1'b1;
            bus.in_bit   = v[n-1-i];
            g = 0;
            while (bus.in_ready !== 1'b1 && g < 20) begin
                @(negedge clock);
                g++;
            end
            if (g >= 20) chk("in_ready_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic wait_send_low();
        int g;
        g = 0;
        do begin
            @(negedge clock);
            g++;
        end while (bus.out_sending !== 1'b0 && g < 40);
        chk("out_sending_falls", {31'd0, bus.out_sending}, 32'd0);
    endtask

    task automatic run_pkt(input string name, input logic [15:0] v, input int n,
                           input logic [15:0] e, input int m, input int stuffs);
        push_exp(e, m);
        send_cycles  = 0;
        stall_cycles = 0;
        drive_bits(v, n);
        @(negedge clock);
        bus.in_valid = 1'b0;
        wait_send_low();
        chk({name, "_sending_len"}, send_cycles, m);
        chk({name, "_stall_cycles"}, stall_cycles, stuffs);
        chk({name, "_wait_ready_low"}, {31'd0, bus.in_ready}, 32'd0);
        chk({name, "_queue_drained"}, exp_q.size(), 32'd0);
    endtask

    task automatic pulse_done();
        @(negedge clock);
        bus.tx_done = 1'b1;
        @(negedge clock);
        bus.tx_done = 1'b0;
        chk("idle_ready_after_done", {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b0;
        bus.in_bit   = 1'b0;
        bus.in_valid = 1'b0;
        bus.tx_done  = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_out_sending", {31'd0, bus.out_sending}, 32'd0);
        chk("reset_out_bit", {31'd0, bus.out_bit}, 32'd0);
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        reset_n = 1'b1;

        // Plain packet 1,0,0,1 -> 0,1,0,0; WAIT_DONE holds until tx_done.
        run_pkt("plain", 16'b1001, 4, 16'b0100, 4, 0);
        repeat (3) @(negedge clock);
        chk("plain_wait_holds", {31'd0, bus.in_ready}, 32'd0);
        pulse_done();

        // 1x7 then 0 -> stuff after the sixth 1.
        run_pkt("mid", 16'b11111110, 8, 16'b000000110, 9, 1);
        pulse_done();

        // Packet ends on a completed run: stuffed bit still goes out.
        run_pkt("trail", 16'b0111111, 7, 16'b11111110, 8, 1);
        pulse_done();

        // Twelve 1s -> two stuffed bits.
        run_pkt("twelve", 16'hFFF, 12, 16'b00000011111110, 14, 2);
        // tx_done outside WAIT_DONE is ignored: pulse it while idle? Here we
        // are in WAIT_DONE, so release normally.
        pulse_done();

        // Single 0 leaves the line at J; the next packet must restart at K.
        run_pkt("single", 16'b0, 1, 16'b1, 1, 0);
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        push_exp(16'b0, 1);
        send_cycles  = 0;
        stall_cycles = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("gate_ready_low", {31'd0, bus.in_ready}, 32'd0);
            chk("gate_not_sending", {31'd0, bus.out_sending}, 32'd0);
        end
        bus.tx_done = 1'b1;
        @(negedge clock);
        bus.tx_done = 1'b0;
        chk("gate_ready_after_done", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;
        wait_send_low();
        chk("gate_sending_len", send_cycles, 1);
        chk("gate_queue_drained", exp_q.size(), 32'd0);
        pulse_done();

        // tx_done while idle must not disturb the next packet.
        @(negedge clock);
        bus.tx_done = 1'b1;
        @(negedge clock);
        bus.tx_done = 1'b0;
        chk("stray_done_idle", {31'd0, bus.in_ready}, 32'd1);

        // Reset mid-packet after two bits (0,1 -> 1,1).
        push_exp(16'b11, 2);
        drive_bits(16'b01, 2);
        @(negedge clock);
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("midrst_out_sending", {31'd0, bus.out_sending}, 32'd0);
        chk("midrst_out_bit", {31'd0, bus.out_bit}, 32'd0);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("midrst_queue_drained", exp_q.size(), 32'd0);
        reset_n = 1'b1;

        // After reset, 0,0 encodes from K: 1,0.
        run_pkt("postrst", 16'b00, 2, 16'b10, 2, 0);
        pulse_done();

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
